// File: rtl/adder_seq_chunked_pkg.sv
// Shared definitions for the chunked sequential adder/subtractor:
// FSM state encodings and a constant clog2 helper.
package adder_seq_chunked_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_seq_chunked_chunk.sv
// CHUNK-bit combinational ripple of full-adder cells. Also exposes the carry
// into the chunk MSB so the caller can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry held in a
// flop between slices. Subtraction is x + ~y + 1.
module adder_seq_chunked
  import adder_seq_chunked_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  int unsigned        shamt;
  logic [CHUNK-1:0]   a_chunk, b_chunk, chunk_sum;
  logic               chunk_cout, chunk_cmsb;
  logic [WIDTH-1:0]   chunk_mask, chunk_ins;

  // Select the current slice by shifting rather than indexing, so the slice
  // position is idx*CHUNK regardless of parameters.
  always_comb begin
    shamt      = 32'(idx_q) * 32'(CHUNK);
    a_chunk    = CHUNK'(a_q >> shamt);
    b_chunk    = CHUNK'(b_q >> shamt);
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    chunk_ins  = WIDTH'(chunk_sum) << shamt;
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = x;
          b_d     = sub ? ~y : y;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        sum_d   = (sum_q & ~chunk_mask) | chunk_ins;
        carry_d = chunk_cout;
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_cmsb;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; both ready and valid are decoded from state alone.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
